cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the two result producers in the Tomasulo back end: ALU and load/store buffer (LSB).
- Per-source result FIFOs absorb collisions; one result is broadcast per cycle.
- The dispatcher, RS, LSB and ROB all snoop the CDB outputs for operand wake-up and completion marking.

---
 rtl/cdb_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the single common data bus (CDB) between the ALU and the load/store
// buffer (LSB). Each source has a small result FIFO that absorbs collisions.
// At most one result is broadcast per cycle from a registered output stage.
// A result that arrives with its FIFO empty and wins arbitration bypasses the
// FIFO. It is broadcast on the next cycle.
//
// Build option:
//   CDB_LSB_PRIORITY_EN  defined   -> LSB wins every contested cycle (no rr)
//                        undefined -> round-robin between ALU and LSB
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   rdy                       global enable; low freezes all state
//   is_clear                  mispredict flush (synchronous)
//   alu_valid/val/rob_id      ALU result beat in
//   alu_ready                 ALU FIFO can accept
//   lsb_valid/val/rob_id      LSB result beat in
//   lsb_ready                 LSB FIFO can accept
//   cdb_valid/val/rob_id/src  registered broadcast (src: 0 = ALU, 1 = LSB)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              is_clear,
    input  logic              alu_valid,
    input  logic [DATA_W-1:0] alu_val,
    input  logic [TAG_W-1:0]  alu_rob_id,
    output logic              alu_ready,
    input  logic              lsb_valid,
    input  logic [DATA_W-1:0] lsb_val,
    input  logic [TAG_W-1:0]  lsb_rob_id,
    output logic              lsb_ready,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_val,
    output logic [TAG_W-1:0]  cdb_rob_id,
    output logic              cdb_src
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // One extra bit so that a full FIFO is distinguishable from an empty one.
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam int SRC_ALU = 0;
    localparam int SRC_LSB = 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } beat_t;

    // Index 0 = ALU, index 1 = LSB throughout.
    beat_t            mem_q    [2][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [CNT_W-1:0] cnt_q    [2];
    logic [CNT_W-1:0] cnt_d    [2];

    beat_t            in_beat   [2];
    beat_t            cand_beat [2];
    beat_t            win_beat;
    logic [1:0]       in_valid;
    logic [1:0]       ready;
    logic [1:0]       accept;
    logic [1:0]       head_vld;
    logic [1:0]       cand;
    logic [1:0]       gnt;
    logic [1:0]       push;
    logic [1:0]       pop;

    logic              cdb_valid_q;
    logic [DATA_W-1:0] cdb_val_q;
    logic [TAG_W-1:0]  cdb_rob_id_q;
    logic              cdb_src_q;

`ifndef CDB_LSB_PRIORITY_EN
    // Round-robin pointer: source that wins the next contested cycle.
    logic rr_q;
    logic rr_d;
`endif

    assign in_beat[SRC_ALU] = {alu_rob_id, alu_val};
    assign in_beat[SRC_LSB] = {lsb_rob_id, lsb_val};
    assign in_valid         = {lsb_valid, alu_valid};

    // Per-source acceptance and candidate selection. Ready depends only on
    // registered count, so producers never see a path from their own valid.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        ready        = '0;
        accept       = '0;
        head_vld     = '0;
        cand         = '0;
        cand_beat[0] = '0;
        cand_beat[1] = '0;
        for (int s = 0; s < 2; s++) begin
            ready[s]     = rdy && rst && (cnt_q[s] < FULL_CNT);
            accept[s]    = in_valid[s] && ready[s] && !is_clear;
            head_vld[s]  = (cnt_q[s] != '0);
            cand[s]      = head_vld[s] || accept[s];
            // A queued head always goes before a new beat from the same source.
            cand_beat[s] = head_vld[s] ? mem_q[s][rd_ptr_q[s]] : in_beat[s];
        end
    end

    assign alu_ready = ready[SRC_ALU];
    assign lsb_ready = ready[SRC_LSB];

    // Arbitration between the two candidates.
    always_comb begin
        gnt  = '0;
`ifndef CDB_LSB_PRIORITY_EN
        rr_d = rr_q;
`endif
        if (cand[SRC_ALU] && cand[SRC_LSB]) begin
`ifdef CDB_LSB_PRIORITY_EN
            gnt[SRC_LSB] = 1'b1;
`else
            gnt[rr_q] = 1'b1;
            // The pointer only moves when both sources were actually competing.
            rr_d      = ~rr_q;
`endif
        end else begin
            gnt = cand;
        end
    end

    assign win_beat = gnt[SRC_LSB] ? cand_beat[SRC_LSB] : cand_beat[SRC_ALU];

    // A granted head pops. An accepted beat is pushed unless it went straight
    // out on the bus, which happens only when its FIFO was empty and it won.
    assign pop  = gnt & head_vld;
    assign push = accept & ~(gnt & ~head_vld);

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            cnt_d[s]    = cnt_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            wr_ptr_d[s] = wr_ptr_q[s];
            if (push[s] && !pop[s]) begin
                cnt_d[s] = cnt_q[s] + CNT_ONE;
            end else if (pop[s] && !push[s]) begin
                cnt_d[s] = cnt_q[s] - CNT_ONE;
            end
            // Depth is a power of two, so pointers wrap naturally.
            if (pop[s]) begin
                rd_ptr_d[s] = rd_ptr_q[s] + PTR_ONE;
            end
            if (push[s]) begin
                wr_ptr_d[s] = wr_ptr_q[s] + PTR_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s]    <= '0;
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
            end
            cdb_valid_q  <= 1'b0;
            cdb_val_q    <= '0;
            cdb_rob_id_q <= '0;
            cdb_src_q    <= 1'b0;
`ifndef CDB_LSB_PRIORITY_EN
            rr_q         <= 1'b0;
`endif
        end else if (rdy) begin
            if (is_clear) begin
                // Flush drops everything queued. The bus data fields keep their
                // last values; only the valid bit is cleared.
                for (int s = 0; s < 2; s++) begin
                    cnt_q[s]    <= '0;
                    rd_ptr_q[s] <= '0;
                    wr_ptr_q[s] <= '0;
                end
                cdb_valid_q <= 1'b0;
`ifndef CDB_LSB_PRIORITY_EN
                rr_q        <= 1'b0;
`endif
            end else begin
                for (int s = 0; s < 2; s++) begin
                    cnt_q[s]    <= cnt_d[s];
                    rd_ptr_q[s] <= rd_ptr_d[s];
                    wr_ptr_q[s] <= wr_ptr_d[s];
                end
                cdb_valid_q <= |gnt;
                if (|gnt) begin
                    cdb_val_q    <= win_beat.val;
                    cdb_rob_id_q <= win_beat.tag;
                    cdb_src_q    <= gnt[SRC_LSB];
                end
`ifndef CDB_LSB_PRIORITY_EN
                rr_q <= rr_d;
`endif
            end
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only read after the count
    // says it was written, so its power-up contents never reach the bus.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                mem_q[s][wr_ptr_q[s]] <= in_beat[s];
            end
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_val    = cdb_val_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter (FIFO_DEPTH=2, DATA_W=32, TAG_W=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values follow the round-robin build unless CDB_LSB_PRIORITY_EN is
// defined, in which case the LSB wins every contested cycle.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int DATA_W     = 32;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 2;

`ifdef CDB_LSB_PRIORITY_EN
    localparam bit LSB_PRIO = 1'b1;
`else
    localparam bit LSB_PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              is_clear;
    logic              alu_valid;
    logic [DATA_W-1:0] alu_val;
    logic [TAG_W-1:0]  alu_rob_id;
    logic              alu_ready;
    logic              lsb_valid;
    logic [DATA_W-1:0] lsb_val;
    logic [TAG_W-1:0]  lsb_rob_id;
    logic              lsb_ready;
    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_val;
    logic [TAG_W-1:0]  cdb_rob_id;
    logic              cdb_src;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard queues of accepted values per source (tag = value[3:0]).
    logic [DATA_W-1:0] exp_a [$];
    logic [DATA_W-1:0] exp_l [$];

    typedef logic [1+1+TAG_W+DATA_W-1:0] obs_t;

    cdb_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .is_clear   (is_clear),
        .alu_valid  (alu_valid),
        .alu_val    (alu_val),
        .alu_rob_id (alu_rob_id),
        .alu_ready  (alu_ready),
        .lsb_valid  (lsb_valid),
        .lsb_val    (lsb_val),
        .lsb_rob_id (lsb_rob_id),
        .lsb_ready  (lsb_ready),
        .cdb_valid  (cdb_valid),
        .cdb_val    (cdb_val),
        .cdb_rob_id (cdb_rob_id),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    function automatic obs_t pack(input logic v, input logic s,
                                  input logic [TAG_W-1:0] t,
                                  input logic [DATA_W-1:0] d);
        return {v, s, t, d};
    endfunction

    function automatic obs_t observed();
        return {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [TAG_W-1:0] t,
                             input logic [DATA_W-1:0] d);
        alu_valid  = v;
        alu_rob_id = t;
        alu_val    = d;
    endtask

    task automatic drive_lsb(input logic v, input logic [TAG_W-1:0] t,
                             input logic [DATA_W-1:0] d);
        lsb_valid  = v;
        lsb_rob_id = t;
        lsb_val    = d;
    endtask

    // ALU (0xA, tag 1) and LSB (0xB, tag 2) in the same cycle.
    task automatic collide(input string name, input logic first_src);
        obs_t exp_alu;
        obs_t exp_lsb;
        exp_alu = pack(1'b1, 1'b0, 4'd1, 32'h0000_000A);
        exp_lsb = pack(1'b1, 1'b1, 4'd2, 32'h0000_000B);
        drive_alu(1'b1, 4'd1, 32'h0000_000A);
        drive_lsb(1'b1, 4'd2, 32'h0000_000B);
        tick();
        drive_alu(1'b0, '0, '0);
        drive_lsb(1'b0, '0, '0);
        vectors++;
        if (observed() !== (first_src ? exp_lsb : exp_alu)) begin
            miscompares++;
            $display("FAIL %s_first: got %h want %h", name, observed(),
                     first_src ? exp_lsb : exp_alu);
        end
        tick();
        vectors++;
        if (observed() !== (first_src ? exp_alu : exp_lsb)) begin
            miscompares++;
            $display("FAIL %s_second: got %h want %h", name, observed(),
                     first_src ? exp_alu : exp_lsb);
        end
        tick();
        vectors++;
        if (cdb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: cdb_valid got %b want 0", name, cdb_valid);
        end
    endtask

    // Three cycles of both sources valid: ALU tags 1..3, LSB tags 9..11.
    task automatic fill();
        for (int i = 0; i < 3; i++) begin
            drive_alu(1'b1, TAG_W'(1 + i), 32'h0000_0A00 + DATA_W'(i));
            drive_lsb(1'b1, TAG_W'(9 + i), 32'h0000_0B00 + DATA_W'(i));
            tick();
        end
        drive_alu(1'b0, '0, '0);
        drive_lsb(1'b0, '0, '0);
    endtask

    // Compares the current broadcast against the head of its source queue.
    task automatic sb_check(input string name);
        logic [DATA_W-1:0] front;
        if ((cdb_src === 1'b0 && exp_a.size() == 0) ||
            (cdb_src === 1'b1 && exp_l.size() == 0) ||
            (cdb_src !== 1'b0 && cdb_src !== 1'b1)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected broadcast src=%b tag=%0d val=%h",
                     name, cdb_src, cdb_rob_id, cdb_val);
        end else begin
            front = (cdb_src === 1'b0) ? exp_a.pop_front() : exp_l.pop_front();
            vectors++;
            if ({cdb_rob_id, cdb_val} !== {front[TAG_W-1:0], front}) begin
                miscompares++;
                $display("FAIL %s: src=%b got tag=%0d val=%h want tag=%0d val=%h",
                         name, cdb_src, cdb_rob_id, cdb_val, front[TAG_W-1:0], front);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (observed() !== pack(1'b0, 1'b0, '0, '0)) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", observed());
        end
        vectors++;
        if ({alu_ready, lsb_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready_low: got %b want 00", {alu_ready, lsb_ready});
        end
        tick();
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({alu_ready, lsb_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_ready_high: got %b want 11", {alu_ready, lsb_ready});
        end
        tick();
        vectors++;
        if (cdb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: cdb_valid got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_single();
        drive_alu(1'b1, 4'd3, 32'h0000_1234);
        tick();
        drive_alu(1'b0, '0, '0);
        vectors++;
        if (observed() !== pack(1'b1, 1'b0, 4'd3, 32'h0000_1234)) begin
            miscompares++;
            $display("FAIL single_n1: got %h want %h", observed(),
                     pack(1'b1, 1'b0, 4'd3, 32'h0000_1234));
        end
        tick();
        vectors++;
        if (cdb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_n2: cdb_valid got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_collision();
        collide("coll1", LSB_PRIO ? 1'b1 : 1'b0);
        collide("coll2", 1'b1);
    endtask

    task automatic test_backpressure();
        int   a_seq = 0;
        int   l_seq = 0;
        logic a_acc;
        logic l_acc;
        logic [3:0] src_pat;
        src_pat = LSB_PRIO ? 4'b1111 : 4'b1010;
        for (int step = 1; step <= 10; step++) begin
            drive_alu(1'b1, TAG_W'(a_seq), 32'hA000_0000 | DATA_W'(a_seq));
            drive_lsb(1'b1, TAG_W'(l_seq), 32'hB000_0000 | DATA_W'(l_seq));
            a_acc = alu_ready;
            l_acc = lsb_ready;
            if (a_acc) exp_a.push_back(32'hA000_0000 | DATA_W'(a_seq));
            if (l_acc) exp_l.push_back(32'hB000_0000 | DATA_W'(l_seq));
            tick();
            vectors++;
            if (cdb_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_valid step %0d: got %b want 1", step, cdb_valid);
            end else begin
                sb_check("bp_hold");
            end
            if (step <= 4) begin
                vectors++;
                if (cdb_src !== src_pat[step-1]) begin
                    miscompares++;
                    $display("FAIL bp_src step %0d: got %b want %b", step, cdb_src,
                             src_pat[step-1]);
                end
            end
`ifdef CDB_LSB_PRIORITY_EN
            if (step == 2) begin
                vectors++;
                if ({alu_ready, lsb_ready} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL bp_ready step 2: got %b want 01", {alu_ready, lsb_ready});
                end
            end
`else
            if (step == 3) begin
                vectors++;
                if ({alu_ready, lsb_ready} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL bp_ready step 3: got %b want 10", {alu_ready, lsb_ready});
                end
            end
            if (step == 4) begin
                vectors++;
                if ({alu_ready, lsb_ready} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL bp_ready step 4: got %b want 01", {alu_ready, lsb_ready});
                end
            end
`endif
            if (a_acc) a_seq++;
            if (l_acc) l_seq++;
        end
        drive_alu(1'b0, '0, '0);
        drive_lsb(1'b0, '0, '0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cdb_valid === 1'b1) sb_check("bp_drain");
        end
        vectors++;
        if (exp_a.size() != 0) begin
            miscompares++;
            $display("FAIL bp_alu_lost: %0d ALU results never broadcast, want 0", exp_a.size());
        end
        vectors++;
        if (exp_l.size() != 0) begin
            miscompares++;
            $display("FAIL bp_lsb_lost: %0d LSB results never broadcast, want 0", exp_l.size());
        end
    endtask

    task automatic test_reset_mid_traffic();
        fill();
        vectors++;
        if (cdb_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre_reset: cdb_valid got %b want 1", cdb_valid);
        end
        #3 rst = 1'b0;
        #1;
        vectors++;
        if (cdb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async: cdb_valid got %b want 0", cdb_valid);
        end
        vectors++;
        if ({alu_ready, lsb_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_ready_low: got %b want 00", {alu_ready, lsb_ready});
        end
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({alu_ready, lsb_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_ready_high: got %b want 11", {alu_ready, lsb_ready});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (cdb_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_empty %0d: cdb_valid got %b want 0", i, cdb_valid);
            end
        end
        collide("mid_rr1", LSB_PRIO ? 1'b1 : 1'b0);
        collide("mid_rr2", 1'b1);
    endtask

    task automatic test_flush();
        obs_t hold;
        hold = LSB_PRIO ? pack(1'b1, 1'b1, 4'd11, 32'h0000_0B02)
                        : pack(1'b1, 1'b0, 4'd2,  32'h0000_0A01);
        fill();
        vectors++;
        if (observed() !== hold) begin
            miscompares++;
            $display("FAIL flush_pre: got %h want %h", observed(), hold);
        end
        drive_alu(1'b1, 4'd7, 32'h0000_0777);
        drive_lsb(1'b1, 4'd8, 32'h0000_0888);
        is_clear = 1'b1;
        tick();
        is_clear = 1'b0;
        drive_alu(1'b0, '0, '0);
        drive_lsb(1'b0, '0, '0);
        vectors++;
        if (observed() !== {1'b0, hold[1+TAG_W+DATA_W-1:0]}) begin
            miscompares++;
            $display("FAIL flush_n1: got %h want %h", observed(),
                     {1'b0, hold[1+TAG_W+DATA_W-1:0]});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (cdb_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_empty %0d: cdb_valid got %b tag %0d want 0", i,
                         cdb_valid, cdb_rob_id);
            end
        end
        collide("flush_rr", LSB_PRIO ? 1'b1 : 1'b0);
    endtask

    task automatic test_stall();
        logic s5;
        obs_t held;
        obs_t after;
        s5    = LSB_PRIO ? 1'b1 : 1'b0;
        held  = pack(1'b1, s5,  4'd5, 32'h0000_5555);
        after = pack(1'b1, ~s5, 4'd6, 32'h0000_6666);
        // One flush cycle returns the round-robin pointer to ALU.
        is_clear = 1'b1;
        tick();
        is_clear = 1'b0;
        if (s5) begin
            drive_lsb(1'b1, 4'd5, 32'h0000_5555);
            drive_alu(1'b1, 4'd6, 32'h0000_6666);
        end else begin
            drive_alu(1'b1, 4'd5, 32'h0000_5555);
            drive_lsb(1'b1, 4'd6, 32'h0000_6666);
        end
        tick();
        drive_alu(1'b0, '0, '0);
        drive_lsb(1'b0, '0, '0);
        vectors++;
        if (observed() !== held) begin
            miscompares++;
            $display("FAIL stall_pre: got %h want %h", observed(), held);
        end
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // Middle stall cycle: a flush and a new beat that must both be ignored.
            is_clear = (i == 1);
            if (i == 1) drive_alu(1'b1, 4'd9, 32'h0000_0999);
            else        drive_alu(1'b0, '0, '0);
            tick();
            vectors++;
            if (observed() !== held) begin
                miscompares++;
                $display("FAIL stall_hold %0d: got %h want %h", i, observed(), held);
            end
            vectors++;
            if ({alu_ready, lsb_ready} !== 2'b00) begin
                miscompares++;
                $display("FAIL stall_ready %0d: got %b want 00", i, {alu_ready, lsb_ready});
            end
        end
        is_clear = 1'b0;
        drive_alu(1'b0, '0, '0);
        rdy = 1'b1;
        tick();
        vectors++;
        if (observed() !== after) begin
            miscompares++;
            $display("FAIL stall_resume: got %h want %h", observed(), after);
        end
        tick();
        vectors++;
        if (cdb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle: cdb_valid got %b want 0", cdb_valid);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        is_clear = 1'b0;
        drive_alu(1'b0, '0, '0);
        drive_lsb(1'b0, '0, '0);
        test_reset();
        test_single();
        test_collision();
        test_backpressure();
        test_reset_mid_traffic();
        test_flush();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
